// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states, mux selects, ALU ops.
// Pure declarations; no timing or flow control of its own.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef logic [3:0] state_t;
    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_EXER   = 4'd6;
    localparam state_t S_EXEI   = 4'd7;
    localparam state_t S_ALUWB  = 4'd8;
    localparam state_t S_JAL    = 4'd9;
    localparam state_t S_BEQ    = 4'd10;
    localparam state_t S_TRAP   = 4'd11;

    typedef logic [1:0] immsrc_t;
    localparam immsrc_t IMM_I = 2'b00;
    localparam immsrc_t IMM_S = 2'b01;
    localparam immsrc_t IMM_B = 2'b10;
    localparam immsrc_t IMM_J = 2'b11;

    typedef logic [2:0] alucontrol_t;
    localparam alucontrol_t ALU_ADD = 3'b000;
    localparam alucontrol_t ALU_SUB = 3'b001;
    localparam alucontrol_t ALU_AND = 3'b010;
    localparam alucontrol_t ALU_OR  = 3'b011;
    localparam alucontrol_t ALU_SLT = 3'b101;

    typedef logic [1:0] resultsrc_t;
    localparam resultsrc_t RES_ALUOUT    = 2'b00;
    localparam resultsrc_t RES_DATA      = 2'b01;
    localparam resultsrc_t RES_ALURESULT = 2'b10;

    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_SUB   = 2'b01;
    localparam aluop_t ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic immsrc_t imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU operation decoder: aluop + funct fields -> alucontrol, purely combinational (0 cycles).
// No flow control; output follows inputs in the same cycle.
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [2:0]  i_funct3,
    input  logic        i_op5,
    input  logic        i_funct7b5,
    output alucontrol_t o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op[5]=1) can request sub; addi ignores funct7.
                    3'b000:  o_alucontrol = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alucontrol = ALU_SLT;
                    3'b110:  o_alucontrol = ALU_OR;
                    3'b111:  o_alucontrol = ALU_AND;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control FSM; lw 5 cycles, sw/R/I/jal 4, beq 3, +1 per memory wait cycle.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready_i; MC_CTRL_PERF_EN adds cycle/instret counters.
module mc_control_unit
    import riscv_pkg::*;
`ifdef MC_CTRL_PERF_EN
#(
    parameter int XLEN = 32
)
`endif
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        memwrite_o,
    output logic        adrsrc_o,
    output logic        irwrite_o,
    output logic        pcwrite_o,
    output logic        regwrite_o,
    output logic [1:0]  resultsrc_o,
    output logic [1:0]  alusrca_o,
    output logic [1:0]  alusrcb_o,
    output logic [1:0]  immsrc_o,
    output logic [2:0]  alucontrol_o,
    output logic        illegal_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [XLEN-1:0] cycle_o,
    output logic [XLEN-1:0] instret_o
`endif
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    aluop_t w_aluop;
    logic   w_req, w_memwrite, w_irwrite, w_pcwrite, w_regwrite;

    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_pcwrite   = 1'b0;
        w_regwrite  = 1'b0;
        adrsrc_o    = 1'b0;
        resultsrc_o = RES_ALUOUT;
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_RS2;
        w_aluop     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_req       = 1'b1;
                alusrcb_o   = SRCB_FOUR;
                resultsrc_o = RES_ALURESULT;
                if (mem_ready_i) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca_o = SRCA_OLDPC;
                alusrcb_o = SRCB_IMM;
                case (op_i)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXER;
                    OP_I:         w_next = S_EXEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca_o = SRCA_RS1;
                alusrcb_o = SRCB_IMM;
                w_next    = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_req    = 1'b1;
                adrsrc_o = 1'b1;
                if (mem_ready_i) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc_o = RES_DATA;
                w_regwrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                w_req      = 1'b1;
                w_memwrite = 1'b1;
                adrsrc_o   = 1'b1;
                if (mem_ready_i) w_next = S_FETCH;
            end
            S_EXER: begin
                alusrca_o = SRCA_RS1;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXEI: begin
                alusrca_o = SRCA_RS1;
                alusrcb_o = SRCB_IMM;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                alusrca_o = SRCA_OLDPC;
                alusrcb_o = SRCB_FOUR;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BEQ: begin
                alusrca_o = SRCA_RS1;
                w_aluop   = ALUOP_SUB;
                w_pcwrite = zero_i;
                w_next    = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct3     (funct3_i),
        .i_op5        (op_i[5]),
        .i_funct7b5   (funct7b5_i),
        .o_alucontrol (alucontrol_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    // Strobes are masked by reset itself so an aborted instruction cannot write.
    assign mem_req_o  = w_req      & ~rst_i;
    assign memwrite_o = w_memwrite & ~rst_i;
    assign irwrite_o  = w_irwrite  & ~rst_i;
    assign pcwrite_o  = w_pcwrite  & ~rst_i;
    assign regwrite_o = w_regwrite & ~rst_i;
    assign immsrc_o   = imm_sel(op_i);
    assign illegal_o  = r_illegal;

`ifdef MC_CTRL_PERF_EN
    logic [XLEN-1:0] r_cycle, r_instret;
    logic            w_retire;

    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (w_retire) r_instret <= r_instret + 1'b1;
        end
    end

    assign cycle_o   = r_cycle;
    assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction expected output traces built from the ISA-level step list.
module tb_mc_control_unit;
    import riscv_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i, zero_i, mem_ready_i;
    logic       mem_req_o, memwrite_o, adrsrc_o, irwrite_o, pcwrite_o, regwrite_o, illegal_o;
    logic [1:0] resultsrc_o, alusrca_o, alusrcb_o, immsrc_o;
    logic [2:0] alucontrol_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_o, instret_o;
`endif

    mc_control_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
        .funct7b5_i(funct7b5_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .memwrite_o(memwrite_o), .adrsrc_o(adrsrc_o),
        .irwrite_o(irwrite_o), .pcwrite_o(pcwrite_o), .regwrite_o(regwrite_o),
        .resultsrc_o(resultsrc_o), .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o),
        .immsrc_o(immsrc_o), .alucontrol_o(alucontrol_o), .illegal_o(illegal_o)
`ifdef MC_CTRL_PERF_EN
        , .cycle_o(cycle_o), .instret_o(instret_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One expected cycle; negative select values mean "don't care".
    typedef struct {
        bit req, mw, irw, pcw, rw, ill;
        int adr, rsrc, a, b, alu, imm;
        bit rdy;
    } step_t;

    step_t q[$];
    int    imm_cur;
    bit    ill_cur;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    model_ret = 0;

    function automatic logic [17:0] exp_of(step_t s);
        logic [17:0] v;
        int r, a, b, al;
        v = 18'b0;
        v[17:12] = {s.req, s.mw, s.irw, s.pcw, s.rw, s.ill};
        v[4:3]   = s.imm[1:0];
        if (s.adr >= 0) v[11] = s.adr[0];
        r = s.rsrc; a = s.a; b = s.b; al = s.alu;
        if (r >= 0)  v[10:9] = r[1:0];
        if (a >= 0)  v[8:7]  = a[1:0];
        if (b >= 0)  v[6:5]  = b[1:0];
        if (al >= 0) v[2:0]  = al[2:0];
        return v;
    endfunction

    function automatic logic [17:0] mask_of(step_t s);
        logic [17:0] m;
        m = 18'h3F018;
        if (s.adr >= 0)  m[11]    = 1'b1;
        if (s.rsrc >= 0) m[10:9]  = 2'b11;
        if (s.a >= 0)    m[8:7]   = 2'b11;
        if (s.b >= 0)    m[6:5]   = 2'b11;
        if (s.alu >= 0)  m[2:0]   = 3'b111;
        return m;
    endfunction

    function automatic int ref_alu(logic [6:0] op, logic [2:0] f3, logic f7);
        case (f3)
            3'd0:    return (op[5] && f7) ? 1 : 0;
            3'd2:    return 5;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return 0;
        endcase
    endfunction

    task automatic push(input bit req, mw, irw, pcw, rw, input int adr, rsrc, a, b, alu, rdy);
        step_t s;
        s.req = req; s.mw = mw; s.irw = irw; s.pcw = pcw; s.rw = rw; s.ill = ill_cur;
        s.adr = adr; s.rsrc = rsrc; s.a = a; s.b = b; s.alu = alu; s.imm = imm_cur;
        s.rdy = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
        q.push_back(s);
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, other = opcode 0 (illegal)
    task automatic load_instr(input int kind, input logic [2:0] f3, input logic f7,
                              input logic z, input int wf, input int wm);
        logic [6:0] op;
        case (kind)
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b1101111;
            5: op = 7'b1100011;
            default: op = 7'b0000000;
        endcase
        op_i = op; funct3_i = f3; funct7b5_i = f7; zero_i = z;
        imm_cur = (kind == 1) ? 1 : (kind == 5) ? 2 : (kind == 4) ? 3 : 0;
        ill_cur = 1'b0;
        q.delete();
        for (int i = 0; i < wf; i++) push(1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
        push(1, 0, 1, 1, 0, 0, 2, 0, 2, 0, 1);
        push(0, 0, 0, 0, 0, -1, -1, 1, 1, 0, -1);
        case (kind)
            0: begin
                push(0, 0, 0, 0, 0, -1, -1, 2, 1, 0, -1);
                for (int i = 0; i < wm; i++) push(1, 0, 0, 0, 0, 1, -1, -1, -1, -1, 0);
                push(1, 0, 0, 0, 0, 1, -1, -1, -1, -1, 1);
                push(0, 0, 0, 0, 1, -1, 1, -1, -1, -1, -1);
            end
            1: begin
                push(0, 0, 0, 0, 0, -1, -1, 2, 1, 0, -1);
                for (int i = 0; i < wm; i++) push(1, 1, 0, 0, 0, 1, -1, -1, -1, -1, 0);
                push(1, 1, 0, 0, 0, 1, -1, -1, -1, -1, 1);
            end
            2, 3: begin
                push(0, 0, 0, 0, 0, -1, -1, 2, (kind == 2) ? 0 : 1, ref_alu(op, f3, f7), -1);
                push(0, 0, 0, 0, 1, -1, 0, -1, -1, -1, -1);
            end
            4: begin
                push(0, 0, 0, 1, 0, -1, 0, 1, 2, 0, -1);
                push(0, 0, 0, 0, 1, -1, 0, -1, -1, -1, -1);
            end
            5: push(0, 0, 0, z, 0, -1, 0, 2, 0, 1, -1);
            default: begin
                ill_cur = 1'b1;
                for (int i = 0; i < 4; i++) push(0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
            end
        endcase
    endtask

    // Entered just after a rising edge; samples on the falling edge.
    task automatic do_step(input step_t s, output logic [17:0] obs);
        mem_ready_i = s.rdy;
        @(negedge clk_i);
        obs = {mem_req_o, memwrite_o, irwrite_o, pcwrite_o, regwrite_o, illegal_o, adrsrc_o,
               resultsrc_o, alusrca_o, alusrcb_o, immsrc_o, alucontrol_o};
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        logic [17:0] obs;
        step_t s;
        rst_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if ({mem_req_o, memwrite_o, irwrite_o, pcwrite_o, regwrite_o, illegal_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_initial: strobes+illegal=%b want 000000",
                     {mem_req_o, memwrite_o, irwrite_o, pcwrite_o, regwrite_o, illegal_o});
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        load_instr(0, 3'd0, 1'b0, 1'b0, 0, 2);
        for (int i = 0; i < 4; i++) begin
            s = q.pop_front();
            do_step(s, obs);
            n_tests++;
            if ((obs & mask_of(s)) !== exp_of(s)) begin
                n_fail++;
                $display("FAIL reset_pre step %0d: got %b want %b care %b", i, obs, exp_of(s), mask_of(s));
            end
        end
        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if ({mem_req_o, memwrite_o, irwrite_o, pcwrite_o, regwrite_o, illegal_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_memrd: strobes+illegal=%b want 000000",
                     {mem_req_o, memwrite_o, irwrite_o, pcwrite_o, regwrite_o, illegal_o});
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_ret = 0;
        load_instr(0, 3'd0, 1'b0, 1'b0, 1, 0);
        s = q[0];
        do_step(s, obs);
        n_tests++;
        if ((obs & mask_of(s)) !== exp_of(s)) begin
            n_fail++;
            $display("FAIL reset_then_fetch: got %b want %b care %b", obs, exp_of(s), mask_of(s));
        end
    endtask

    task automatic test_lw;
        logic [17:0] obs;
        step_t s;
        int i;
        load_instr(0, 3'd2, 1'b0, 1'b0, 0, 0);
        i = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            do_step(s, obs);
            n_tests++;
            if ((obs & mask_of(s)) !== exp_of(s)) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %b want %b care %b", i + 1, obs, exp_of(s), mask_of(s));
            end
            i++;
        end
        model_ret++;
    endtask

    task automatic test_sw_wait;
        logic [17:0] obs;
        step_t s;
        int i, n_mw;
        load_instr(1, 3'd2, 1'b0, 1'b0, 0, 3);
        i = 0; n_mw = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            do_step(s, obs);
            if (obs[16]) n_mw++;
            n_tests++;
            if ((obs & mask_of(s)) !== exp_of(s)) begin
                n_fail++;
                $display("FAIL sw_wait cycle %0d: got %b want %b care %b", i + 1, obs, exp_of(s), mask_of(s));
            end
            i++;
        end
        n_tests++;
        if (n_mw !== 4) begin
            n_fail++;
            $display("FAIL sw_memwrite_len: got %0d cycles want 4", n_mw);
        end
        model_ret++;
    endtask

    task automatic test_beq;
        logic [17:0] obs;
        step_t s;
        for (int z = 1; z >= 0; z--) begin
            load_instr(5, 3'd0, 1'b0, 1'(z), 0, 0);
            while (q.size() > 0) begin
                s = q.pop_front();
                do_step(s, obs);
                n_tests++;
                if ((obs & mask_of(s)) !== exp_of(s)) begin
                    n_fail++;
                    $display("FAIL beq zero=%0d: got %b want %b care %b", z, obs, exp_of(s), mask_of(s));
                end
            end
            model_ret++;
        end
    endtask

    task automatic test_alu_decode;
        logic [17:0] obs;
        step_t s;
        int kinds[3] = '{2, 3, 2};
        logic [2:0] f3s[3] = '{3'd0, 3'd0, 3'd2};
        for (int t = 0; t < 3; t++) begin
            load_instr(kinds[t], f3s[t], 1'b1, 1'b0, 0, 0);
            while (q.size() > 0) begin
                s = q.pop_front();
                do_step(s, obs);
                n_tests++;
                if ((obs & mask_of(s)) !== exp_of(s)) begin
                    n_fail++;
                    $display("FAIL alu_decode case %0d: got %b want %b care %b", t, obs, exp_of(s), mask_of(s));
                end
            end
            model_ret++;
        end
    endtask

    task automatic test_random;
        logic [17:0] obs;
        step_t s;
        for (int n = 0; n < 80; n++) begin
            load_instr($urandom_range(0, 5), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
            while (q.size() > 0) begin
                s = q.pop_front();
                do_step(s, obs);
                n_tests++;
                if ((obs & mask_of(s)) !== exp_of(s)) begin
                    n_fail++;
                    $display("FAIL random instr %0d op=%b: got %b want %b care %b",
                             n, op_i, obs, exp_of(s), mask_of(s));
                end
            end
            model_ret++;
`ifdef MC_CTRL_PERF_EN
            n_tests++;
            if (instret_o !== 32'(model_ret)) begin
                n_fail++;
                $display("FAIL instret after instr %0d: got %0d want %0d", n, instret_o, model_ret);
            end
`endif
        end
    endtask

    task automatic test_trap;
        logic [17:0] obs;
        step_t s;
        load_instr(6, 3'd0, 1'b0, 1'b0, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            do_step(s, obs);
            n_tests++;
            if ((obs & mask_of(s)) !== exp_of(s)) begin
                n_fail++;
                $display("FAIL trap: got %b want %b care %b", obs, exp_of(s), mask_of(s));
            end
        end
`ifdef MC_CTRL_PERF_EN
        n_tests++;
        if (instret_o !== 32'(model_ret)) begin
            n_fail++;
            $display("FAIL trap_instret: got %0d want %0d", instret_o, model_ret);
        end
`endif
        rst_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (illegal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_reset_clears: illegal_o=%b want 0", illegal_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; op_i = 7'b0; funct3_i = 3'b0; funct7b5_i = 1'b0;
        zero_i = 1'b0; mem_ready_i = 1'b0;
        imm_cur = 0; ill_cur = 1'b0;
        test_reset;
        test_lw;
        test_sw_wait;
        test_beq;
        test_alu_decode;
        test_random;
        test_trap;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
